bit_collector_6: RTL and testbench
==================================

# bit_collector_6

Sequential 6-way bit collector: the write-side counterpart of the team's 6-to-1 bit-select mux. It accepts addressed single-bit writes (`in_sel`, `in_bit`) and places each bit at `out_word[in_sel]`. Once all six positions have been written, it presents the assembled word on a valid/ready output. It sits between a serial or addressed bit source and any consumer of a parallel 6-bit word.

## Interface
Parameters:
- `N`, default 6: word width, which is also the number of addressable positions.
- `SEL_W`, default 3: select width, equal to `$clog2(N)`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  write request.
- `in_ready`  out  1  write can be accepted this cycle.
- `in_sel`  in  `SEL_W`  target bit position.
- `in_bit`  in  1  data bit.
- `clear`  in  1  synchronous abort of the partial or pending word.
- `out_valid`  out  1  `out_word` holds a complete word.
- `out_ready`  in  1  consumer accepts the word.
- `out_word`  out  `N`  assembled word.
- `sel_err`  out  1  one-cycle pulse: the previous accepted write had `in_sel >= N`.
- `busy`  out  1  the accumulator holds at least one written position.

## Operation
- **Internal state:**
  - accumulator `acc[N]`;
  - written-mask `mask[N]`;
  - output register `out_word` with `out_valid`;
  - FSM with states IDLE, COLLECT, FULL_WAIT.
- **Write acceptance:** a write is accepted when `in_valid && in_ready`.
- **Valid select** (`in_sel < N`):
  - `acc[in_sel] <= in_bit` and `mask[in_sel] <= 1`.
  - Rewriting an already-written position overwrites the bit; the mask is unchanged.
- **Invalid select** (`in_sel` = 6 or 7 at N=6):
  - The write is accepted and dropped.
  - `acc` and `mask` are unchanged.
  - `sel_err` = 1 on the next cycle.
- **Completion:** an accepted write that makes `mask` all-ones completes the word.
  - If the output register is free (`!out_valid`) or draining this cycle (`out_valid && out_ready`): `out_word <=` the completed `acc` (including this write's bit), `out_valid <= 1`, `acc`/`mask` clear, and the FSM goes to IDLE.
  - Otherwise the FSM goes to FULL_WAIT and holds `acc`.
- **FSM transitions:**
  - IDLE → COLLECT on the first accepted valid-select write that does not complete the word.
  - COLLECT → IDLE or FULL_WAIT on completion, as above.
  - FULL_WAIT → IDLE on the cycle `out_valid && out_ready`. `acc` is loaded into `out_word`, and `out_valid` stays 1.
- **Ready and busy:**
  - `in_ready = !rst && !clear && state != FULL_WAIT`.
  - `busy = (state != IDLE)`.
- **Output handshake:**
  - `out_valid` is cleared on `out_valid && out_ready` unless a new word loads in the same cycle.
  - `out_word` is stable while `out_valid && !out_ready`.
- **Clear:**
  - Zeroes `acc` and `mask` and sends the FSM to IDLE, discarding any FULL_WAIT word.
  - Does not affect `out_word` or `out_valid`.
  - Has priority over a same-cycle write, which is not accepted because `in_ready` = 0.
- **Reset:** all outputs 0.
  - `out_word` = 0, `out_valid` = 0, `sel_err` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst` is high, then 1 on the first cycle after.
  - FSM in IDLE; `acc` and `mask` = 0.
  - Reset mid-word discards all data.

## Timing
- **Latency:** the completing write accepted in cycle t gives `out_valid` = 1 with the word in cycle t+1.
- **Throughput:** one accepted write per cycle, sustained while the consumer keeps `out_ready` = 1.
- **Back-to-back words:** write 1 of the next word is accepted in the cycle after completion.
- **FSM and outputs:** registered except `in_ready`, which is combinational from state, `clear` and `rst`.
- **`sel_err`:** registered, one-cycle pulse per invalid write.
- **Simultaneous events:**
  - Completion and `out_ready` in the same cycle: direct load, no FULL_WAIT.
  - `clear` and `out_ready` in the same cycle: both take effect.
  - FULL_WAIT drain: `out_valid` remains high across the word boundary.

## Structure
- **Shared package `bit_collector_pkg`:**
  - `N` and `SEL_W` defaults;
  - FSM state typedef (IDLE/COLLECT/FULL_WAIT);
  - all-ones mask constant.
- **Sub-module `bit_collector_out_reg`:** the output holding register with valid/ready. It has a load input and exposes a "free or draining" flag to the FSM.
- **Top level:** accumulator, mask, FSM and `sel_err` logic.

## Test plan
- **In-order word:** after reset, write sel 0..5 with bits 1,0,1,1,0,1, `out_ready` = 1 → `out_word` = 6'b101101 and `out_valid` = 1 exactly one cycle after the 6th write.
- **Out-of-order with overwrite:** write sel 5,3,3,0,1,2,4 with bits 1,1,0,0,1,1,0 → word 6'b100110; `out_valid` rises only after the 7th write.
- **Invalid select:** write sel 6 and sel 7 mid-word → `sel_err` pulses once each, `mask`/`acc` unchanged, completed word unaffected.
- **Backpressure:** hold `out_ready` = 0, complete word A (6'b111111), then complete word B (6'b000000).
  - Checks while stalled: `in_ready` = 0 in FULL_WAIT and `out_word` holds A.
  - Pulse `out_ready`: B appears next cycle with `out_valid` continuous.
  - Then `in_ready` = 1.
- **Clear and reset mid-operation:**
  - Clear after 3 writes → `busy` = 0; the next 6 writes form a fresh word.
  - `rst` asserted in FULL_WAIT → all outputs 0 and no word emitted.
- **Clear race:** assert `clear` with `in_valid` on what would be the completing write → no `out_valid`; `busy` = 0 next cycle.

Source files
------------

// File: rtl/bit_collector_pkg.sv
// Shared types and defaults for the 6-way bit collector.
// Imported by the interface, the output register and the top.
package bit_collector_pkg;

  localparam int N_DEF     = 6;
  localparam int SEL_W_DEF = 3;

  localparam logic [N_DEF-1:0] MASK_FULL = '1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL_WAIT
  } state_t;

endpackage

// File: rtl/bit_collector_6_if.sv
// Write-side and word-side handshake bundle for the bit collector.
// master drives writes and consumes words; slave is the collector.
interface bit_collector_6_if
  import bit_collector_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_word;

  modport master (
    output in_valid,
    output in_sel,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_word
  );

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_word
  );

endinterface

// File: rtl/bit_collector_out_reg.sv
// Output holding register with valid/ready for the bit collector.
// free is high when a load this cycle cannot overwrite an unread word.
module bit_collector_out_reg
  import bit_collector_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] word,
  output logic         free
);

  assign free = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_collector_6.sv
// Collects addressed single-bit writes into an N-bit word and
// hands the completed word to a valid/ready consumer.
module bit_collector_6
  import bit_collector_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  bit_collector_6_if.slave bus,
  input  logic         clear,
  output logic         sel_err,
  output logic         busy
);

  state_t state, state_n;

  logic [SEL_W-1:0] sel;
  logic [N-1:0]     acc, acc_n;
  logic [N-1:0]     mask, mask_n;
  logic [N-1:0]     bit_m, acc_w, mask_w;
  logic [N-1:0]     load_word;
  logic             accept, sel_ok, done;
  logic             free, load, drain;

  assign sel    = bus.in_sel;
  assign sel_ok = 32'(sel) < N;
  assign bit_m  = sel_ok ? (N'(1) << sel) : '0;
  assign acc_w  = (acc & ~bit_m) | (bus.in_bit ? bit_m : '0);
  assign mask_w = mask | bit_m;

  assign bus.in_ready = !rst && !clear && (state != FULL_WAIT);
  assign accept = bus.in_valid && bus.in_ready;
  assign done   = accept && sel_ok && (&mask_w);
  assign drain  = bus.out_valid && bus.out_ready;
  assign busy   = (state != IDLE);

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mask_n    = mask;
    load      = 1'b0;
    load_word = acc;
    if (clear) begin
      state_n = IDLE;
      acc_n   = '0;
      mask_n  = '0;
    end else begin
      unique case (state)
        IDLE, COLLECT: begin
          if (done && free) begin
            load      = 1'b1;
            load_word = acc_w;
            acc_n     = '0;
            mask_n    = '0;
            state_n   = IDLE;
          end else if (done) begin
            acc_n   = acc_w;
            mask_n  = mask_w;
            state_n = FULL_WAIT;
          end else if (accept && sel_ok) begin
            acc_n   = acc_w;
            mask_n  = mask_w;
            state_n = COLLECT;
          end
        end
        FULL_WAIT: begin
          // the parked word moves up as the old one drains
          if (drain) begin
            load    = 1'b1;
            acc_n   = '0;
            mask_n  = '0;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      mask    <= '0;
      sel_err <= 1'b0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mask    <= mask_n;
      sel_err <= accept && !sel_ok;
    end
  end

  bit_collector_out_reg #(.N(N)) u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .d     (load_word),
    .ready (bus.out_ready),
    .valid (bus.out_valid),
    .word  (bus.out_word),
    .free  (free)
  );

endmodule

// File: tb/tb_bit_collector_6.sv
// Directed scenarios plus a randomized run against a word-level
// reference model of the bit collector.
module tb_bit_collector_6;
  import bit_collector_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic sel_err, busy;
  int checks = 0;
  int errors = 0;

  bit_collector_6_if bus ();

  bit_collector_6 dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .clear   (clear),
    .sel_err (sel_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int s, input logic b);
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'(s);
    bus.in_bit   = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_word !== 6'd0) begin errors++; $display("FAIL rst_out_word got %b want 0", bus.out_word); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (sel_err !== 1'b0) begin errors++; $display("FAIL rst_sel_err got %b want 0", sel_err); end
    rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_in_order();
    logic [5:0] bits;
    bits = 6'b101101;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put(i, bits[i]);
      if (i == 4) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL inord_early got %b want 0", bus.out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL inord_busy got %b want 1", busy); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL inord_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_word !== 6'b101101) begin errors++; $display("FAIL inord_word got %b want 101101", bus.out_word); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inord_idle got %b want 0", busy); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL inord_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_out_of_order();
    int sels[7] = '{5, 3, 3, 0, 1, 2, 4};
    logic bv[7] = '{1, 1, 0, 0, 1, 1, 0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      put(sels[i], bv[i]);
      if (i == 5) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ooo_early got %b want 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ooo_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_word !== 6'b100110) begin errors++; $display("FAIL ooo_word got %b want 100110", bus.out_word); end
    tick();
  endtask

  task automatic test_invalid_sel();
    int sels[8] = '{0, 1, 6, 2, 7, 3, 4, 5};
    logic bv[8] = '{1, 0, 1, 1, 0, 0, 1, 1};
    logic ee[8] = '{0, 0, 1, 0, 1, 0, 0, 0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      put(sels[i], bv[i]);
      checks++; if (sel_err !== ee[i]) begin errors++; $display("FAIL inv_sel_err step %0d got %b want %b", i, sel_err, ee[i]); end
      if (i == 6) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL inv_early got %b want 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_word !== 6'b110101) begin errors++; $display("FAIL inv_word got %b want 110101", bus.out_word); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(i, 1'b1);
    for (int i = 0; i < 6; i++) put(i, 1'b0);
    repeat (2) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
      checks++; if (bus.out_word !== 6'b111111) begin errors++; $display("FAIL bp_hold got %b want 111111", bus.out_word); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b want 1", busy); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_cont got %b want 1", bus.out_valid); end
    checks++; if (bus.out_word !== 6'b000000) begin errors++; $display("FAIL bp_word_b got %b want 000000", bus.out_word); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_clear();
    int sels[6] = '{3, 4, 5, 0, 1, 2};
    logic bv[6] = '{1, 0, 1, 0, 1, 0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) put(i, 1'b1);
    clear = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready got %b want 0", bus.in_ready); end
    tick();
    clear = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
    for (int i = 0; i < 6; i++) begin
      put(sels[i], bv[i]);
      if (i == 4) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_early got %b want 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_word !== 6'b101010) begin errors++; $display("FAIL clr_word got %b want 101010", bus.out_word); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(i, 1'b1);
    for (int i = 0; i < 6; i++) put(i, 1'b1);
    rst = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_word !== 6'd0) begin errors++; $display("FAIL rmid_word got %b want 0", bus.out_word); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b want 0", bus.in_ready); end
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ghost got %b want 0", bus.out_valid); end
  endtask

  task automatic test_clear_race();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) put(i, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_sel   = 3'd5;
    bus.in_bit   = 1'b1;
    clear = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL race_ready got %b want 0", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    clear = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL race_valid got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL race_busy got %b want 0", busy); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL race_late got %b want 0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [5:0] bits, written, pw, ow, lw;
    logic pend, ov, err, ld, drain, free, acc, xr;
    logic v, b, c, r;
    int s;
    bits = '0; written = '0; pw = '0; ow = '0;
    pend = 0; ov = 0; err = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3000) begin
      v = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, 7);
      b = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 39) == 0);
      r = ($urandom_range(0, 9) < 6);
      bus.in_valid = v; bus.in_sel = 3'(s); bus.in_bit = b;
      clear = c; bus.out_ready = r;
      #1;
      xr = !c && !pend;
      checks++; if (bus.in_ready !== xr) begin errors++; $display("FAIL rnd_in_ready got %b want %b", bus.in_ready, xr); end
      checks++; if (bus.out_valid !== ov) begin errors++; $display("FAIL rnd_out_valid got %b want %b", bus.out_valid, ov); end
      checks++; if (bus.out_word !== ow) begin errors++; $display("FAIL rnd_out_word got %b want %b", bus.out_word, ow); end
      checks++; if (busy !== ((written != 0) || pend)) begin errors++; $display("FAIL rnd_busy got %b want %b", busy, (written != 0) || pend); end
      checks++; if (sel_err !== err) begin errors++; $display("FAIL rnd_sel_err got %b want %b", sel_err, err); end
      acc = v && xr;
      drain = ov && r;
      free = !ov || r;
      err = acc && (s >= 6);
      ld = 0; lw = '0;
      if (c) begin
        bits = '0; written = '0; pend = 0;
      end else if (pend) begin
        if (drain) begin ld = 1; lw = pw; pend = 0; end
      end else if (acc && s < 6) begin
        bits[s] = b;
        written[s] = 1'b1;
        if (written == MASK_FULL) begin
          if (free) begin ld = 1; lw = bits; end
          else begin pend = 1; pw = bits; end
          bits = '0; written = '0;
        end
      end
      if (ld) begin ov = 1; ow = lw; end
      else if (drain) ov = 0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_bit    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_in_order();
    test_out_of_order();
    test_invalid_sel();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_clear_race();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
